// File: rtl/axi_ctrl_lite_bridge.sv
// AXI4 (64-bit) slave to AXI-Lite (32-bit) master bridge for an HLS accelerator control port.
// Define CTRL_BRIDGE_BURST_EN to split len>0 bursts into per-beat Lite transactions.
module axi_ctrl_lite_bridge #(
  parameter int ID_W    = 12,
  parameter int LITE_AW = 6
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_aresetn,
  input  logic [ID_W-1:0]    s_axi_awid,
  input  logic [63:0]        s_axi_awaddr,
  input  logic [7:0]         s_axi_awlen,
  input  logic [2:0]         s_axi_awsize,
  input  logic [1:0]         s_axi_awburst,
  input  logic               s_axi_awvalid,
  output logic               s_axi_awready,
  input  logic [63:0]        s_axi_wdata,
  input  logic [7:0]         s_axi_wstrb,
  input  logic               s_axi_wlast,
  input  logic               s_axi_wvalid,
  output logic               s_axi_wready,
  output logic [ID_W-1:0]    s_axi_bid,
  output logic [1:0]         s_axi_bresp,
  output logic               s_axi_bvalid,
  input  logic               s_axi_bready,
  input  logic [ID_W-1:0]    s_axi_arid,
  input  logic [63:0]        s_axi_araddr,
  input  logic [7:0]         s_axi_arlen,
  input  logic [2:0]         s_axi_arsize,
  input  logic [1:0]         s_axi_arburst,
  input  logic               s_axi_arvalid,
  output logic               s_axi_arready,
  output logic [ID_W-1:0]    s_axi_rid,
  output logic [63:0]        s_axi_rdata,
  output logic [1:0]         s_axi_rresp,
  output logic               s_axi_rlast,
  output logic               s_axi_rvalid,
  input  logic               s_axi_rready,
  output logic [LITE_AW-1:0] m_lite_awaddr,
  output logic               m_lite_awvalid,
  input  logic               m_lite_awready,
  output logic [31:0]        m_lite_wdata,
  output logic [3:0]         m_lite_wstrb,
  output logic               m_lite_wvalid,
  input  logic               m_lite_wready,
  input  logic [1:0]         m_lite_bresp,
  input  logic               m_lite_bvalid,
  output logic               m_lite_bready,
  output logic [LITE_AW-1:0] m_lite_araddr,
  output logic               m_lite_arvalid,
  input  logic               m_lite_arready,
  input  logic [31:0]        m_lite_rdata,
  input  logic [1:0]         m_lite_rresp,
  input  logic               m_lite_rvalid,
  output logic               m_lite_rready
);

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, W_DATA, W_LITE, W_RESP, B_OUT, R_LITE, R_WAIT, R_OUT
  } state_t;

  state_t state, state_next;

  logic               run;
  logic [ID_W-1:0]    id_q;
  logic [LITE_AW-1:0] addr_q;
  logic [LITE_AW-1:0] addr_adv;
  logic [7:0]         len_q;
  logic [7:0]         cnt_q;
  logic [2:0]         size_q;
  logic [1:0]         burst_q;
  logic               err_q;
  logic               prio_wr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic               aw_done_q;
  logic               w_done_q;
  logic [1:0]         resp_q;
  logic [31:0]        rdata_q;
  logic [1:0]         rresp_q;
  logic               aw_err;
  logic               ar_err;
  logic               last_beat;
  logic               w_hs;
  logic               lite_aw_hs;
  logic               lite_w_hs;
  logic               lite_b_hs;
  logic               lite_r_hs;
  logic               r_hs;
  logic               adv;
  logic               unused_ok;

  function automatic logic [LITE_AW-1:0] beat_addr(input logic [LITE_AW-1:0] a,
                                                   input logic [2:0]         size,
                                                   input logic [1:0]         burst);
    if (burst == 2'b00) return a;
    return a + (LITE_AW'(1) << size);
  endfunction

  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

`ifdef CTRL_BRIDGE_BURST_EN
  assign aw_err = (s_axi_awsize > 3'd2);
  assign ar_err = (s_axi_arsize > 3'd2);
`else
  // Without burst support any multi-beat request is answered locally with SLVERR.
  assign aw_err = (s_axi_awsize > 3'd2) || (s_axi_awlen != 8'd0);
  assign ar_err = (s_axi_arsize > 3'd2) || (s_axi_arlen != 8'd0);
`endif

  assign run        = s_axi_aresetn;
  assign last_beat  = (cnt_q == len_q);
  assign addr_adv   = beat_addr(addr_q, size_q, burst_q);
  assign w_hs       = s_axi_wready && s_axi_wvalid;
  assign lite_aw_hs = m_lite_awvalid && m_lite_awready;
  assign lite_w_hs  = m_lite_wvalid && m_lite_wready;
  assign lite_b_hs  = m_lite_bready && m_lite_bvalid;
  assign lite_r_hs  = m_lite_rready && m_lite_rvalid;
  assign r_hs       = s_axi_rvalid && s_axi_rready;
  assign adv        = ((w_hs && err_q) || lite_b_hs || r_hs) && !last_beat;

  assign s_axi_bid     = id_q;
  assign s_axi_bresp   = resp_q;
  assign s_axi_rid     = id_q;
  assign s_axi_rdata   = {rdata_q, rdata_q};
  assign s_axi_rresp   = rresp_q;
  assign m_lite_awaddr = addr_q;
  assign m_lite_araddr = addr_q;
  assign m_lite_wdata  = wdata_q;
  assign m_lite_wstrb  = wstrb_q;

  assign unused_ok = ^{s_axi_awaddr[63:LITE_AW], s_axi_araddr[63:LITE_AW], s_axi_wlast};

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next     = state;
    s_axi_awready  = 1'b0;
    s_axi_arready  = 1'b0;
    s_axi_wready   = 1'b0;
    s_axi_bvalid   = 1'b0;
    s_axi_rvalid   = 1'b0;
    s_axi_rlast    = 1'b0;
    m_lite_awvalid = 1'b0;
    m_lite_wvalid  = 1'b0;
    m_lite_bready  = 1'b0;
    m_lite_arvalid = 1'b0;
    m_lite_rready  = 1'b0;
    case (state)
      IDLE: begin
        if (s_axi_awvalid && (!s_axi_arvalid || prio_wr_q)) begin
          s_axi_awready = run;
          state_next    = W_DATA;
        end else if (s_axi_arvalid) begin
          s_axi_arready = run;
          state_next    = ar_err ? R_OUT : R_LITE;
        end
      end
      W_DATA: begin
        s_axi_wready = run;
        if (s_axi_wvalid) begin
          if (!err_q)         state_next = W_LITE;
          else if (last_beat) state_next = B_OUT;
        end
      end
      W_LITE: begin
        m_lite_awvalid = run && !aw_done_q;
        m_lite_wvalid  = run && !w_done_q;
        if ((aw_done_q || m_lite_awready) && (w_done_q || m_lite_wready))
          state_next = W_RESP;
      end
      W_RESP: begin
        m_lite_bready = run;
        if (m_lite_bvalid) state_next = last_beat ? B_OUT : W_DATA;
      end
      B_OUT: begin
        s_axi_bvalid = run;
        if (s_axi_bready) state_next = IDLE;
      end
      R_LITE: begin
        m_lite_arvalid = run;
        if (m_lite_arready) state_next = R_WAIT;
      end
      R_WAIT: begin
        m_lite_rready = run;
        if (m_lite_rvalid) state_next = R_OUT;
      end
      R_OUT: begin
        s_axi_rvalid = run;
        s_axi_rlast  = run && last_beat;
        if (s_axi_rready) begin
          if (last_beat)  state_next = IDLE;
          else if (err_q) state_next = R_OUT;
          else            state_next = R_LITE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, beat bookkeeping and data steering.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      prio_wr_q <= 1'b1;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      resp_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      // Priority only flips when both channels compete, so a lone request never spends the other side's turn.
      if (s_axi_awready) begin
        id_q    <= s_axi_awid;
        addr_q  <= s_axi_awaddr[LITE_AW-1:0];
        len_q   <= s_axi_awlen;
        size_q  <= s_axi_awsize;
        burst_q <= s_axi_awburst;
        cnt_q   <= '0;
        err_q   <= aw_err;
        resp_q  <= '0;
        if (s_axi_arvalid) prio_wr_q <= 1'b0;
      end
      if (s_axi_arready) begin
        id_q    <= s_axi_arid;
        addr_q  <= s_axi_araddr[LITE_AW-1:0];
        len_q   <= s_axi_arlen;
        size_q  <= s_axi_arsize;
        burst_q <= s_axi_arburst;
        cnt_q   <= '0;
        err_q   <= ar_err;
        if (s_axi_awvalid) prio_wr_q <= 1'b1;
        if (ar_err) begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end
      end
      if (w_hs) begin
        wdata_q   <= addr_q[2] ? s_axi_wdata[63:32] : s_axi_wdata[31:0];
        wstrb_q   <= addr_q[2] ? s_axi_wstrb[7:4]   : s_axi_wstrb[3:0];
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        if (err_q) resp_q <= RESP_SLVERR;
      end
      if (lite_aw_hs) aw_done_q <= 1'b1;
      if (lite_w_hs)  w_done_q  <= 1'b1;
      if (lite_b_hs)  resp_q    <= worst_resp(resp_q, m_lite_bresp);
      if (lite_r_hs) begin
        rdata_q <= m_lite_rdata;
        rresp_q <= m_lite_rresp;
      end
      if (adv) begin
        cnt_q  <= cnt_q + 8'd1;
        addr_q <= addr_adv;
      end
    end
  end

endmodule

// File: tb/tb_axi_ctrl_lite_bridge.sv
// Directed bench for axi_ctrl_lite_bridge: bench acts as host master and zero-wait Lite slave,
// expected traffic is queued when stimulus is issued and checked as each handshake happens.
module tb_axi_ctrl_lite_bridge;
  localparam int ID_W    = 12;
  localparam int LITE_AW = 6;

  logic               clk = 1'b0;
  logic               s_axi_aresetn;
  logic [ID_W-1:0]    s_axi_awid;
  logic [63:0]        s_axi_awaddr;
  logic [7:0]         s_axi_awlen;
  logic [2:0]         s_axi_awsize;
  logic [1:0]         s_axi_awburst;
  logic               s_axi_awvalid;
  logic               s_axi_awready;
  logic [63:0]        s_axi_wdata;
  logic [7:0]         s_axi_wstrb;
  logic               s_axi_wlast;
  logic               s_axi_wvalid;
  logic               s_axi_wready;
  logic [ID_W-1:0]    s_axi_bid;
  logic [1:0]         s_axi_bresp;
  logic               s_axi_bvalid;
  logic               s_axi_bready;
  logic [ID_W-1:0]    s_axi_arid;
  logic [63:0]        s_axi_araddr;
  logic [7:0]         s_axi_arlen;
  logic [2:0]         s_axi_arsize;
  logic [1:0]         s_axi_arburst;
  logic               s_axi_arvalid;
  logic               s_axi_arready;
  logic [ID_W-1:0]    s_axi_rid;
  logic [63:0]        s_axi_rdata;
  logic [1:0]         s_axi_rresp;
  logic               s_axi_rlast;
  logic               s_axi_rvalid;
  logic               s_axi_rready;
  logic [LITE_AW-1:0] m_lite_awaddr;
  logic               m_lite_awvalid;
  logic               m_lite_awready;
  logic [31:0]        m_lite_wdata;
  logic [3:0]         m_lite_wstrb;
  logic               m_lite_wvalid;
  logic               m_lite_wready;
  logic [1:0]         m_lite_bresp;
  logic               m_lite_bvalid;
  logic               m_lite_bready;
  logic [LITE_AW-1:0] m_lite_araddr;
  logic               m_lite_arvalid;
  logic               m_lite_arready;
  logic [31:0]        m_lite_rdata;
  logic [1:0]         m_lite_rresp;
  logic               m_lite_rvalid;
  logic               m_lite_rready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int addr_cyc = 0;
  int lat_b   = 0;
  int lat_r   = 0;

  logic [LITE_AW-1:0] exp_law[$];
  logic [35:0]        exp_lw[$];
  logic [LITE_AW-1:0] exp_lar[$];
  logic [ID_W+1:0]    exp_b[$];
  logic [ID_W+66:0]   exp_r[$];
  logic               exp_ord[$];
  logic [31:0]        lite_rdata_q[$];

  logic got_aw, got_w, got_ar, r_stall;
  logic [31:0] r_data;
  logic [1:0]  lite_bresp_val;

  axi_ctrl_lite_bridge #(.ID_W(ID_W), .LITE_AW(LITE_AW)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(s_axi_aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_lite_awaddr(m_lite_awaddr), .m_lite_awvalid(m_lite_awvalid), .m_lite_awready(m_lite_awready),
    .m_lite_wdata(m_lite_wdata), .m_lite_wstrb(m_lite_wstrb), .m_lite_wvalid(m_lite_wvalid),
    .m_lite_wready(m_lite_wready),
    .m_lite_bresp(m_lite_bresp), .m_lite_bvalid(m_lite_bvalid), .m_lite_bready(m_lite_bready),
    .m_lite_araddr(m_lite_araddr), .m_lite_arvalid(m_lite_arvalid), .m_lite_arready(m_lite_arready),
    .m_lite_rdata(m_lite_rdata), .m_lite_rresp(m_lite_rresp), .m_lite_rvalid(m_lite_rvalid),
    .m_lite_rready(m_lite_rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lite slave: responds in the cycle after the request handshakes complete.
  assign m_lite_bvalid = got_aw && got_w;
  assign m_lite_bresp  = lite_bresp_val;
  assign m_lite_rvalid = got_ar && !r_stall;
  assign m_lite_rdata  = r_data;
  assign m_lite_rresp  = 2'b00;

  always @(posedge clk) begin
    if (!s_axi_aresetn) begin
      got_aw <= 1'b0;
      got_w  <= 1'b0;
      got_ar <= 1'b0;
    end else begin
      if (m_lite_awvalid && m_lite_awready) got_aw <= 1'b1;
      if (m_lite_wvalid && m_lite_wready)   got_w  <= 1'b1;
      if (m_lite_bvalid && m_lite_bready) begin
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end
      if (m_lite_arvalid && m_lite_arready) begin
        got_ar <= 1'b1;
        if (lite_rdata_q.size() != 0) r_data <= lite_rdata_q.pop_front();
      end
      if (m_lite_rvalid && m_lite_rready) got_ar <= 1'b0;
    end
  end

  // Scoreboard: every handshake must match the next queued expectation.
  always @(negedge clk) begin
    if (s_axi_aresetn) begin
      if ((s_axi_awvalid && s_axi_awready) || (s_axi_arvalid && s_axi_arready)) addr_cyc = cyc;
      if (m_lite_awvalid && m_lite_awready) begin
        check("lite_aw_pending", 128'(exp_law.size() != 0), 128'(1));
        if (exp_law.size() != 0) check("lite_awaddr", 128'(m_lite_awaddr), 128'(exp_law.pop_front()));
      end
      if (m_lite_wvalid && m_lite_wready) begin
        check("lite_w_pending", 128'(exp_lw.size() != 0), 128'(1));
        if (exp_lw.size() != 0) check("lite_wdata_strb", 128'({m_lite_wdata, m_lite_wstrb}), 128'(exp_lw.pop_front()));
      end
      if (m_lite_arvalid && m_lite_arready) begin
        check("lite_ar_pending", 128'(exp_lar.size() != 0), 128'(1));
        if (exp_lar.size() != 0) check("lite_araddr", 128'(m_lite_araddr), 128'(exp_lar.pop_front()));
      end
      if (s_axi_bvalid && s_axi_bready) begin
        lat_b = cyc - addr_cyc;
        check("b_pending", 128'(exp_b.size() != 0), 128'(1));
        if (exp_b.size() != 0) check("b_id_resp", 128'({s_axi_bid, s_axi_bresp}), 128'(exp_b.pop_front()));
        check("order_b_pending", 128'(exp_ord.size() != 0), 128'(1));
        if (exp_ord.size() != 0) check("order_b", 128'(1'b0), 128'(exp_ord.pop_front()));
      end
      if (s_axi_rvalid && s_axi_rready) begin
        lat_r = cyc - addr_cyc;
        check("r_pending", 128'(exp_r.size() != 0), 128'(1));
        if (exp_r.size() != 0)
          check("r_id_data_resp_last", 128'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}),
                128'(exp_r.pop_front()));
        if (s_axi_rlast) begin
          check("order_r_pending", 128'(exp_ord.size() != 0), 128'(1));
          if (exp_ord.size() != 0) check("order_r", 128'(1'b1), 128'(exp_ord.pop_front()));
        end
      end
    end
  end

  task automatic exp_lite_wr(input logic [LITE_AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_law.push_back(a);
    exp_lw.push_back({d, s});
  endtask

  task automatic exp_bresp(input logic [ID_W-1:0] id, input logic [1:0] resp);
    exp_b.push_back({id, resp});
    exp_ord.push_back(1'b0);
  endtask

  task automatic exp_rbeat(input logic [ID_W-1:0] id, input logic [31:0] d, input logic [1:0] resp,
                           input logic last);
    exp_r.push_back({id, d, d, resp, last});
    if (last) exp_ord.push_back(1'b1);
  endtask

  task automatic send_aw(input logic [ID_W-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic seen;
    seen = 1'b0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_axi_awready) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    check("aw_accept", 128'(seen), 128'(1));
  endtask

  task automatic send_ar(input logic [ID_W-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic seen;
    seen = 1'b0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    check("ar_accept", 128'(seen), 128'(1));
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    logic seen;
    seen = 1'b0;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_axi_wready) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    check("w_accept", 128'(seen), 128'(1));
  endtask

  task automatic drain(input string tag);
    logic empty;
    empty = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      empty = (exp_law.size() == 0) && (exp_lw.size() == 0) && (exp_lar.size() == 0) &&
              (exp_b.size() == 0) && (exp_r.size() == 0) && (exp_ord.size() == 0);
      if (empty) break;
    end
    @(posedge clk); #1;
    check(tag, 128'(empty), 128'(1));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_host"}, 128'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp,
                                s_axi_arready, s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp,
                                s_axi_rlast}), 128'(0));
    check({tag, "_lite"}, 128'({m_lite_awvalid, m_lite_awaddr, m_lite_wvalid, m_lite_wdata,
                                m_lite_wstrb, m_lite_bready, m_lite_arvalid, m_lite_araddr,
                                m_lite_rready}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_axi_aresetn = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    m_lite_awready = 1'b1; m_lite_wready = 1'b1; m_lite_arready = 1'b1;
    lite_bresp_val = 2'b00; r_stall = 1'b0; r_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    s_axi_aresetn = 1'b1;
    @(posedge clk); #1;

    // Single write, lower lane; 4-cycle latency with zero-wait host and Lite.
    exp_lite_wr(6'h10, 32'hDEADBEEF, 4'hF);
    exp_bresp(12'h123, 2'b00);
    fork
      send_aw(12'h123, 64'h10, 8'd0, 3'd2, 2'b01);
      send_w(64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b1);
    join
    drain("t1_drain");
    check("t1_wr_latency", 128'(lat_b), 128'(4));

    // Upper-lane write.
    exp_lite_wr(6'h14, 32'hCAFEF00D, 4'hF);
    exp_bresp(12'h007, 2'b00);
    fork
      send_aw(12'h007, 64'h14, 8'd0, 3'd2, 2'b01);
      send_w(64'hCAFE_F00D_0000_0000, 8'hF0, 1'b1);
    join
    drain("t2_drain");

    // Single read, data duplicated on both lanes; 3-cycle latency.
    lite_rdata_q.push_back(32'h12345678);
    exp_lar.push_back(6'h04);
    exp_rbeat(12'h05A, 32'h12345678, 2'b00, 1'b1);
    send_ar(12'h05A, 64'h04, 8'd0, 3'd2, 2'b01);
    drain("t3_drain");
    check("t3_rd_latency", 128'(lat_r), 128'(3));

    // Two-beat INCR read, two-beat INCR write and two-beat FIXED read.
`ifdef CTRL_BRIDGE_BURST_EN
    lite_rdata_q.push_back(32'hA0A0A0A0);
    lite_rdata_q.push_back(32'hB1B1B1B1);
    exp_lar.push_back(6'h00);
    exp_lar.push_back(6'h04);
    exp_rbeat(12'h0C4, 32'hA0A0A0A0, 2'b00, 1'b0);
    exp_rbeat(12'h0C4, 32'hB1B1B1B1, 2'b00, 1'b1);
`else
    exp_rbeat(12'h0C4, 32'h0, 2'b10, 1'b0);
    exp_rbeat(12'h0C4, 32'h0, 2'b10, 1'b1);
`endif
    send_ar(12'h0C4, 64'h00, 8'd1, 3'd2, 2'b01);
    drain("t4_rd_burst_drain");

`ifdef CTRL_BRIDGE_BURST_EN
    exp_lite_wr(6'h20, 32'h11111111, 4'hF);
    exp_lite_wr(6'h24, 32'h22222222, 4'hF);
    exp_bresp(12'h0AB, 2'b00);
`else
    exp_bresp(12'h0AB, 2'b10);
`endif
    fork
      send_aw(12'h0AB, 64'h20, 8'd1, 3'd2, 2'b01);
      begin
        send_w(64'h0000_0000_1111_1111, 8'h0F, 1'b0);
        send_w(64'h2222_2222_0000_0000, 8'hF0, 1'b1);
      end
    join
    drain("t4_wr_burst_drain");

`ifdef CTRL_BRIDGE_BURST_EN
    lite_rdata_q.push_back(32'h0F0F0001);
    lite_rdata_q.push_back(32'h0F0F0002);
    exp_lar.push_back(6'h28);
    exp_lar.push_back(6'h28);
    exp_rbeat(12'h0F1, 32'h0F0F0001, 2'b00, 1'b0);
    exp_rbeat(12'h0F1, 32'h0F0F0002, 2'b00, 1'b1);
`else
    exp_rbeat(12'h0F1, 32'h0, 2'b10, 1'b0);
    exp_rbeat(12'h0F1, 32'h0, 2'b10, 1'b1);
`endif
    send_ar(12'h0F1, 64'h28, 8'd1, 3'd2, 2'b00);
    drain("t4_fixed_drain");

    // Oversized transfers: SLVERR with no Lite traffic.
    exp_rbeat(12'h03C, 32'h0, 2'b10, 1'b1);
    send_ar(12'h03C, 64'h08, 8'd0, 3'd3, 2'b01);
    drain("size_rd_drain");
    exp_bresp(12'h0D0, 2'b10);
    fork
      send_aw(12'h0D0, 64'h18, 8'd0, 3'd3, 2'b01);
      send_w(64'h5555_5555_5555_5555, 8'hFF, 1'b1);
    join
    drain("size_wr_drain");

    // Lite W stalled behind AW, and a Lite SLVERR folded into the host response.
    m_lite_wready = 1'b0;
    lite_bresp_val = 2'b10;
    exp_lite_wr(6'h2C, 32'h600DF00D, 4'h3);
    exp_bresp(12'h0EE, 2'b10);
    fork
      send_aw(12'h0EE, 64'h2C, 8'd0, 3'd2, 2'b01);
      send_w(64'h600D_F00D_0000_0000, 8'h30, 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1 m_lite_wready = 1'b1;
      end
    join
    drain("stall_drain");
    lite_bresp_val = 2'b00;

    // Reset while waiting for Lite read data: transaction is dropped.
    r_stall = 1'b1;
    exp_lar.push_back(6'h18);
    send_ar(12'h0F0, 64'h18, 8'd0, 3'd2, 2'b01);
    begin
      logic in_wait;
      in_wait = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (m_lite_rready) begin in_wait = 1'b1; break; end
      end
      check("t6_reach_r_wait", 128'(in_wait), 128'(1));
    end
    s_axi_aresetn = 1'b0;
    @(negedge clk);
    check_quiet("t6_in_reset");
    @(posedge clk); #1;
    s_axi_aresetn = 1'b1;
    r_stall = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_quiet("t6_after_release");
    @(posedge clk); #1;
    drain("t6_drain");

    // Collision right after reset: write first, then the repeat goes to the read.
    lite_rdata_q.push_back(32'h55556666);
    exp_lite_wr(6'h08, 32'h0000AAAA, 4'hF);
    exp_lar.push_back(6'h0C);
    exp_bresp(12'h111, 2'b00);
    exp_rbeat(12'h222, 32'h55556666, 2'b00, 1'b1);
    fork
      send_aw(12'h111, 64'h08, 8'd0, 3'd2, 2'b01);
      send_w(64'h0000_0000_0000_AAAA, 8'h0F, 1'b1);
      send_ar(12'h222, 64'h0C, 8'd0, 3'd2, 2'b01);
    join
    drain("t5_first_drain");

    lite_rdata_q.push_back(32'h99990000);
    exp_lar.push_back(6'h00);
    exp_rbeat(12'h444, 32'h99990000, 2'b00, 1'b1);
    exp_lite_wr(6'h34, 32'h77770000, 4'hF);
    exp_bresp(12'h333, 2'b00);
    fork
      send_aw(12'h333, 64'h34, 8'd0, 3'd2, 2'b01);
      send_w(64'h7777_0000_0000_0000, 8'hF0, 1'b1);
      send_ar(12'h444, 64'h00, 8'd0, 3'd2, 2'b01);
    join
    drain("t5_repeat_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
